// File: rtl/gpio_axi_pkg.sv
// Shared types and constants for the GPIO AXI4-Lite write controller:
// FSM states, write-response codes and the pin-index width.
package gpio_axi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int PIN_W   = 3;
  // Address bits above this index select the 32-byte GPIO window.
  localparam int WIN_LSB = 5;

endpackage

// File: rtl/gpio_axi_write_ctrl_if.sv
// AXI4-Lite write channels (AW, W, B) between a bus master and the GPIO write controller.
// Handshake: a beat transfers on a rising clock edge where valid && ready are both 1;
// the source holds valid and payload stable until then, ready may change freely.
interface gpio_axi_write_ctrl_if;
  logic        AWvalid;
  logic [31:0] AWaddr;
  logic        AWready;
  logic        Wvalid;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Wready;
  logic        Bvalid;
  logic [1:0]  Bresp;
  logic        Bready;

  modport master (
    output AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready,
    input  AWready, Wready, Bvalid, Bresp
  );

  modport slave (
    input  AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready,
    output AWready, Wready, Bvalid, Bresp
  );
endinterface

// File: rtl/gpio_axi_write_ctrl.sv
// AXI4-Lite single-beat write slave driving a one-hot GPIO pin decoder (wr_en/LWAddress/wr_bit).
// Optional macro GPIO_WSTRB_CHECK_EN: Wstrb[0]==0 suppresses the commit strobe on a hit.
module gpio_axi_write_ctrl
  import gpio_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  gpio_axi_write_ctrl_if.slave bus,
  output logic              wr_en,
  output logic [PIN_W-1:0]  LWAddress,
  output logic              wr_bit,
  output state_t            fsm_state
);

  state_t     state;
  logic       aw_done;
  logic       w_done;
  logic       aw_ready_q;
  logic       w_ready_q;
  logic       bvalid_q;
  logic [1:0] bresp_q;
  logic       wr_en_q;
  logic       hit_q;

  logic       aw_hs;
  logic       w_hs;
  logic       hit_now;
  logic       strb_now;

  assign aw_hs   = bus.AWvalid && aw_ready_q;
  assign w_hs    = bus.Wvalid && w_ready_q;
  assign hit_now = aw_hs ? (bus.AWaddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]) : hit_q;

`ifdef GPIO_WSTRB_CHECK_EN
  logic strb_q;
  assign strb_now = w_hs ? bus.Wstrb[0] : strb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      strb_q <= 1'b0;
    end else if (w_hs) begin
      strb_q <= bus.Wstrb[0];
    end
  end
`else
  assign strb_now = 1'b1;
`endif

  // Bits of the bus that carry no meaning for a one-bit GPIO write.
  logic unused_bits;
  assign unused_bits = ^{bus.AWaddr[1:0], bus.Wdata[31:1], bus.Wstrb};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_en_q    <= 1'b0;
      hit_q      <= 1'b0;
      LWAddress  <= '0;
      wr_bit     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            hit_q      <= hit_now;
            LWAddress  <= bus.AWaddr[WIN_LSB-1:2];
            aw_done    <= 1'b1;
            aw_ready_q <= 1'b0;
          end else if (!aw_done) begin
            aw_ready_q <= 1'b1;
          end
          if (w_hs) begin
            wr_bit    <= bus.Wdata[0];
            w_done    <= 1'b1;
            w_ready_q <= 1'b0;
          end else if (!w_done) begin
            w_ready_q <= 1'b1;
          end
          // Both channels may complete in the same cycle, so use the live handshakes too.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= COMMIT;
            wr_en_q <= hit_now && strb_now;
          end
        end
        COMMIT: begin
          state    <= RESP;
          wr_en_q  <= 1'b0;
          bvalid_q <= 1'b1;
          bresp_q  <= hit_q ? RESP_OKAY : RESP_SLVERR;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
        end
        RESP: begin
          if (bus.Bready) begin
            state      <= IDLE;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A reset landing in COMMIT must not let the strobe reach the decoder.
  assign wr_en       = wr_en_q && !reset;
  assign bus.AWready = aw_ready_q;
  assign bus.Wready  = w_ready_q;
  assign bus.Bvalid  = bvalid_q;
  assign bus.Bresp   = bresp_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_gpio_axi_write_ctrl.sv
// Directed self-checking bench for gpio_axi_write_ctrl; expectations hand-computed per scenario.
// Honours GPIO_WSTRB_CHECK_EN when the same macro is defined for the build.
module tb_gpio_axi_write_ctrl;
  import gpio_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [2:0] LWAddress;
  logic       wr_bit;
  state_t     fsm_state;

  int checks;
  int errors;

  gpio_axi_write_ctrl_if bus ();

  gpio_axi_write_ctrl #(.BASE_ADDR(BASE)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .wr_en     (wr_en),
    .LWAddress (LWAddress),
    .wr_bit    (wr_bit),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.AWvalid = 1'b0;
    bus.AWaddr  = 32'h0;
    bus.Wvalid  = 1'b0;
    bus.Wdata   = 32'h0;
    bus.Wstrb   = 4'hF;
    bus.Bready  = 1'b0;
  endtask

  task automatic drive_both(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.AWvalid = 1'b1;
    bus.AWaddr  = addr;
    bus.Wvalid  = 1'b1;
    bus.Wdata   = data;
    bus.Wstrb   = strb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    step();
    step();
    checks++; if (bus.AWready !== 1'b0) begin errors++; $display("FAIL reset_awready: got %b expected 0", bus.AWready); end
    checks++; if (bus.Wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b expected 0", bus.Wready); end
    checks++; if (bus.Bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b expected 0", bus.Bvalid); end
    checks++; if (bus.Bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp: got %b expected 00", bus.Bresp); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (LWAddress !== 3'd0) begin errors++; $display("FAIL reset_lwaddress: got %0d expected 0", LWAddress); end
    checks++; if (wr_bit !== 1'b0) begin errors++; $display("FAIL reset_wr_bit: got %b expected 0", wr_bit); end
    checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
    reset = 1'b0;
    step();
    checks++; if (bus.AWready !== 1'b1) begin errors++; $display("FAIL post_reset_awready: got %b expected 1", bus.AWready); end
    checks++; if (bus.Wready !== 1'b1) begin errors++; $display("FAIL post_reset_wready: got %b expected 1", bus.Wready); end
  endtask

  task automatic test_same_cycle();
    drive_both(BASE + 32'h14, 32'h1, 4'hF);
    step();
    drive_idle();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL same_wr_en: got %b expected 1", wr_en); end
    checks++; if (LWAddress !== 3'd5) begin errors++; $display("FAIL same_lwaddress: got %0d expected 5", LWAddress); end
    checks++; if (wr_bit !== 1'b1) begin errors++; $display("FAIL same_wr_bit: got %b expected 1", wr_bit); end
    checks++; if (bus.AWready !== 1'b0 || bus.Wready !== 1'b0) begin errors++; $display("FAIL same_readys_low: got %b%b expected 00", bus.AWready, bus.Wready); end
    checks++; if (bus.Bvalid !== 1'b0) begin errors++; $display("FAIL same_bvalid_early: got %b expected 0", bus.Bvalid); end
    step();
    checks++; if (bus.Bvalid !== 1'b1) begin errors++; $display("FAIL same_bvalid: got %b expected 1", bus.Bvalid); end
    checks++; if (bus.Bresp !== 2'b00) begin errors++; $display("FAIL same_bresp: got %b expected 00", bus.Bresp); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL same_wr_en_pulse: got %b expected 0", wr_en); end
    bus.Bready = 1'b1;
    step();
    bus.Bready = 1'b0;
    checks++; if (bus.Bvalid !== 1'b0) begin errors++; $display("FAIL same_bvalid_clear: got %b expected 0", bus.Bvalid); end
    checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL same_idle: got %0d expected %0d", fsm_state, IDLE); end
    checks++; if (bus.AWready !== 1'b1 || bus.Wready !== 1'b1) begin errors++; $display("FAIL same_readys_back: got %b%b expected 11", bus.AWready, bus.Wready); end
  endtask

  task automatic test_w_first();
    bus.Wvalid = 1'b1;
    bus.Wdata  = 32'h0;
    step();
    bus.Wvalid = 1'b0;
    checks++; if (bus.Wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_drop: got %b expected 0", bus.Wready); end
    checks++; if (bus.AWready !== 1'b1) begin errors++; $display("FAIL wfirst_awready: got %b expected 1", bus.AWready); end
    step();
    step();
    checks++; if (bus.Wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_hold: got %b expected 0", bus.Wready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wfirst_no_early_commit: got %b expected 0", wr_en); end
    bus.AWvalid = 1'b1;
    bus.AWaddr  = BASE;
    step();
    bus.AWvalid = 1'b0;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL wfirst_wr_en: got %b expected 1", wr_en); end
    checks++; if (LWAddress !== 3'd0) begin errors++; $display("FAIL wfirst_lwaddress: got %0d expected 0", LWAddress); end
    checks++; if (wr_bit !== 1'b0) begin errors++; $display("FAIL wfirst_wr_bit: got %b expected 0", wr_bit); end
    step();
    checks++; if (bus.Bvalid !== 1'b1 || bus.Bresp !== 2'b00) begin errors++; $display("FAIL wfirst_resp: got %b/%b expected 1/00", bus.Bvalid, bus.Bresp); end
    bus.Bready = 1'b1;
    step();
    bus.Bready = 1'b0;
  endtask

  task automatic test_miss_early_bready();
    bus.Bready = 1'b1;
    drive_both(BASE + 32'h20, 32'h1, 4'hF);
    step();
    bus.AWvalid = 1'b0;
    bus.Wvalid  = 1'b0;
    checks++; if (fsm_state !== COMMIT) begin errors++; $display("FAIL miss_commit_state: got %0d expected %0d", fsm_state, COMMIT); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL miss_wr_en: got %b expected 0", wr_en); end
    step();
    checks++; if (bus.Bvalid !== 1'b1) begin errors++; $display("FAIL miss_bvalid: got %b expected 1", bus.Bvalid); end
    checks++; if (bus.Bresp !== 2'b10) begin errors++; $display("FAIL miss_bresp: got %b expected 10", bus.Bresp); end
    step();
    bus.Bready = 1'b0;
    checks++; if (bus.Bvalid !== 1'b0 || fsm_state !== IDLE) begin errors++; $display("FAIL miss_return: got %b/%0d expected 0/%0d", bus.Bvalid, fsm_state, IDLE); end
  endtask

  task automatic test_bready_hold();
    drive_both(BASE + 32'h08, 32'h1, 4'hF);
    step();
    drive_idle();
    checks++; if (wr_en !== 1'b1 || LWAddress !== 3'd2) begin errors++; $display("FAIL hold_commit: got %b/%0d expected 1/2", wr_en, LWAddress); end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.Bvalid !== 1'b1 || bus.Bresp !== 2'b00 || bus.AWready !== 1'b0 || bus.Wready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got bvalid=%b bresp=%b readys=%b%b expected 1 00 00", i, bus.Bvalid, bus.Bresp, bus.AWready, bus.Wready);
      end
      step();
    end
    bus.Bready = 1'b1;
    step();
    bus.Bready = 1'b0;
    checks++; if (bus.Bvalid !== 1'b0 || fsm_state !== IDLE) begin errors++; $display("FAIL hold_release: got %b/%0d expected 0/%0d", bus.Bvalid, fsm_state, IDLE); end
    checks++; if (bus.AWready !== 1'b1 || bus.Wready !== 1'b1) begin errors++; $display("FAIL hold_readys_back: got %b%b expected 11", bus.AWready, bus.Wready); end
  endtask

  task automatic test_reset_in_commit();
    drive_both(BASE + 32'h0C, 32'h1, 4'hF);
    step();
    drive_idle();
    checks++; if (fsm_state !== COMMIT) begin errors++; $display("FAIL rstc_in_commit: got %0d expected %0d", fsm_state, COMMIT); end
    reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rstc_wr_en_same_cycle: got %b expected 0", wr_en); end
    step();
    reset = 1'b0;
    checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL rstc_state: got %0d expected %0d", fsm_state, IDLE); end
    checks++; if (LWAddress !== 3'd0 || wr_bit !== 1'b0) begin errors++; $display("FAIL rstc_captured: got %0d/%b expected 0/0", LWAddress, wr_bit); end
    checks++; if (bus.AWready !== 1'b0 || bus.Wready !== 1'b0 || bus.Bresp !== 2'b00) begin errors++; $display("FAIL rstc_outputs: got %b%b/%b expected 00/00", bus.AWready, bus.Wready, bus.Bresp); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.Bvalid !== 1'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL rstc_quiet%0d: got bvalid=%b wr_en=%b expected 0 0", i, bus.Bvalid, wr_en);
      end
      step();
    end
    checks++; if (bus.AWready !== 1'b1 || bus.Wready !== 1'b1) begin errors++; $display("FAIL rstc_readys_back: got %b%b expected 11", bus.AWready, bus.Wready); end
  endtask

  task automatic test_wstrb();
    logic exp_wr;
`ifdef GPIO_WSTRB_CHECK_EN
    exp_wr = 1'b0;
`else
    exp_wr = 1'b1;
`endif
    drive_both(BASE + 32'h04, 32'h1, 4'h0);
    step();
    drive_idle();
    checks++; if (wr_en !== exp_wr) begin errors++; $display("FAIL wstrb_wr_en: got %b expected %b", wr_en, exp_wr); end
    checks++; if (LWAddress !== 3'd1) begin errors++; $display("FAIL wstrb_lwaddress: got %0d expected 1", LWAddress); end
    step();
    checks++; if (bus.Bvalid !== 1'b1 || bus.Bresp !== 2'b00) begin errors++; $display("FAIL wstrb_resp: got %b/%b expected 1/00", bus.Bvalid, bus.Bresp); end
    bus.Bready = 1'b1;
    step();
    bus.Bready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_miss_early_bready();
    test_bready_hold();
    test_reset_in_commit();
    test_wstrb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_axi_write_ctrl.md
GPIO_AXI_WRITE_CTRL -- requirements
Module: gpio_axi_write_ctrl

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte base address of the GPIO write window; SHALL be 32-byte aligned.
REQ-002 Port clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 Port AWvalid  in  1  AXI4-Lite write-address valid.
REQ-005 Port AWaddr  in  32  AXI4-Lite write byte address.
REQ-006 Port AWready  out  1  write-address ready.
REQ-007 Port Wvalid  in  1  write-data valid.
REQ-008 Port Wdata  in  32  write data; only bit 0 is used (pin level).
REQ-009 Port Wstrb  in  4  write strobes; used only per REQ-026.
REQ-010 Port Wready  out  1  write-data ready.
REQ-011 Port Bvalid  out  1  write-response valid.
REQ-012 Port Bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 Port Bready  in  1  write-response ready.
REQ-014 Port wr_en  out  1  one-cycle commit strobe to the downstream one-hot pin decoder.
REQ-015 Port LWAddress  out  3  pin index to the decoder, equal to AWaddr[4:2] of the captured address.
REQ-016 Port wr_bit  out  1  captured Wdata[0].

Function
REQ-017 FSM states SHALL be IDLE, COMMIT and RESP.
REQ-018 In IDLE: AWready = 1 until an address is captured; Wready = 1 until data is captured; each channel is captured on its own valid&&ready cycle, in either order or in the same cycle.
REQ-019 After capture, the ready of that channel SHALL drop the next cycle and stay low until the next return to IDLE.
REQ-020 The cycle after both channels are captured, the FSM SHALL enter COMMIT; COMMIT SHALL last exactly one cycle, then RESP.
REQ-021 Address hit: AWaddr[31:5] == BASE_ADDR[31:5]; in COMMIT, wr_en SHALL be 1 only on a hit (and per REQ-026), else 0.
REQ-022 LWAddress and wr_bit SHALL hold the captured values from capture until the next capture; they need not be valid when wr_en is 0.
REQ-023 In RESP: Bvalid = 1, Bresp = 2'b00 on hit, 2'b10 on miss; Bvalid and Bresp held stable until Bready; on Bvalid&&Bready, FSM returns to IDLE next cycle.
REQ-024 Latency: last channel handshake at cycle N -> wr_en high at N+1 -> Bvalid high from N+2; minimum 3 cycles per transaction, no overlapping transactions.
REQ-025 Bready asserted early (before RESP) SHALL have no effect.

Configuration
REQ-026 Macro GPIO_WSTRB_CHECK_EN: when defined, Wstrb[0] == 0 on a hit SHALL suppress wr_en while still returning OKAY; when undefined, Wstrb SHALL be ignored.

Reset
REQ-027 On reset: FSM = IDLE, AWready = 0, Wready = 0, Bvalid = 0, Bresp = 2'b00, wr_en = 0, LWAddress = 3'b000, wr_bit = 0; AWready/Wready SHALL rise the first cycle after reset deasserts.
REQ-028 Reset in any state, including COMMIT or RESP, SHALL abort the transaction with no wr_en pulse and no response.

Structure
REQ-029 Shared package gpio_axi_pkg SHALL hold the FSM state enumeration, the OKAY/SLVERR response constants, and the pin-index width (3).
REQ-030 No sub-module; the existing one-hot decoder stays a separate block, instantiated alongside and fed by wr_en/LWAddress.

Verification
REQ-031 AW (AWaddr=BASE+0x14) and W (Wdata=1) in the same cycle -> next cycle wr_en=1, LWAddress=5, wr_bit=1; following cycle Bvalid=1, Bresp=00.
REQ-032 W (Wdata=0) three cycles before AW (AWaddr=BASE+0x00) -> Wready low after its handshake; wr_en=1, LWAddress=0, wr_bit=0 one cycle after AW handshake.
REQ-033 AWaddr=BASE+0x20 -> wr_en stays 0; Bresp=2'b10.
REQ-034 Bready held low for 5 cycles in RESP -> Bvalid/Bresp stable, AWready/Wready stay 0; Bready=1 -> IDLE and readys return next cycle.
REQ-035 Reset asserted during COMMIT -> wr_en=0 in that cycle onward, Bvalid never asserts, all outputs match REQ-027.
REQ-036 With GPIO_WSTRB_CHECK_EN, Wstrb=4'b0000 on a hit -> no wr_en, Bresp=00; without the macro, same stimulus -> wr_en=1.
